// File: rtl/hcsr04_ranger_if.sv
// Trigger/echo and result bundle between the Nios PIO side and the ranging engine.
interface hcsr04_ranger_if #(
    parameter int DIST_W = 9
);
    logic              start;
    logic              auto_en;
    logic              echo_in;
    logic              trig_out;
    logic [DIST_W-1:0] dist_cm;
    logic              dist_valid;
    logic              timeout;
    logic              busy;

    modport master (
        output start, auto_en, echo_in,
        input  trig_out, dist_cm, dist_valid, timeout, busy
    );

    modport slave (
        input  start, auto_en, echo_in,
        output trig_out, dist_cm, dist_valid, timeout, busy
    );
endinterface

// File: rtl/hcsr04_ranger.sv
// HC-SR04 ranging engine: issues the trigger pulse, times the echo in whole
// microseconds and reports the distance in centimetres (saturating, with timeout).
module hcsr04_ranger #(
    parameter int CLK_HZ     = 50000000,
    parameter int TRIG_US    = 10,
    parameter int CM_US      = 58,
    parameter int TIMEOUT_US = 38000,
    parameter int HOLDOFF_US = 60000,
    parameter int DIST_W     = 9
) (
    input  logic           clk_clk,
    input  logic           reset_reset,
    hcsr04_ranger_if.slave rng
);
    localparam int CYC_US = CLK_HZ / 1000000;
    localparam int US_MAX = (TIMEOUT_US > HOLDOFF_US)
                          ? ((TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US)
                          : ((HOLDOFF_US > TRIG_US) ? HOLDOFF_US : TRIG_US);
    localparam int US_W   = $clog2(US_MAX + 1);
    localparam int PRE_W  = (CYC_US > 1) ? $clog2(CYC_US) : 1;
    localparam int SUB_W  = (CM_US > 1) ? $clog2(CM_US) : 1;
    localparam logic [DIST_W-1:0] DIST_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLDOFF
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              echo_m;
    logic              echo_s;
    logic              echo_q;
    logic [PRE_W-1:0]  pre_cnt;
    logic [US_W-1:0]   us_cnt;
    logic [SUB_W-1:0]  cm_sub;
    logic [DIST_W-1:0] cm_cnt;
    logic [DIST_W-1:0] cm_nx;
    logic              us_tick;
    logic              cm_wrap;
    logic              done_ok;
    logic              done_to;

    assign us_tick = (pre_cnt == PRE_W'(CYC_US - 1));
    assign cm_wrap = us_tick && (cm_sub == SUB_W'(CM_US - 1));
    // The exit cycle's own tick must be included, so the result is taken from the next value.
    assign cm_nx   = (cm_wrap && (cm_cnt != DIST_MAX)) ? cm_cnt + DIST_W'(1) : cm_cnt;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        done_ok  = 1'b0;
        done_to  = 1'b0;
        unique case (state)
            IDLE: begin
                if (rng.start || rng.auto_en) state_nx = TRIG;
            end
            TRIG: begin
                if (us_tick && (us_cnt == US_W'(TRIG_US - 1))) state_nx = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (echo_s && !echo_q) begin
                    state_nx = MEASURE;
                end else if (us_tick && (us_cnt == US_W'(TIMEOUT_US - 1))) begin
                    done_to  = 1'b1;
                    state_nx = HOLDOFF;
                end
            end
            MEASURE: begin
                if (!echo_s) begin
                    done_ok  = 1'b1;
                    state_nx = HOLDOFF;
                end else if (us_tick && (us_cnt == US_W'(TIMEOUT_US - 1))) begin
                    done_to  = 1'b1;
                    state_nx = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (us_tick && (us_cnt == US_W'(HOLDOFF_US - 1))) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            echo_m         <= 1'b0;
            echo_s         <= 1'b0;
            echo_q         <= 1'b0;
            pre_cnt        <= '0;
            us_cnt         <= '0;
            cm_sub         <= '0;
            cm_cnt         <= '0;
            rng.trig_out   <= 1'b0;
            rng.busy       <= 1'b0;
            rng.dist_valid <= 1'b0;
            rng.dist_cm    <= '0;
            rng.timeout    <= 1'b0;
        end else begin
            echo_m <= rng.echo_in;
            echo_s <= echo_m;
            echo_q <= echo_s;

            if ((state_nx != state) || (state == IDLE)) begin
                pre_cnt <= '0;
                us_cnt  <= '0;
            end else if (us_tick) begin
                pre_cnt <= '0;
                us_cnt  <= us_cnt + US_W'(1);
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end

            if (state_nx != state) begin
                cm_sub <= '0;
                cm_cnt <= '0;
            end else if ((state == MEASURE) && us_tick) begin
                cm_sub <= cm_wrap ? '0 : cm_sub + SUB_W'(1);
                cm_cnt <= cm_nx;
            end

            rng.trig_out   <= (state == TRIG);
            rng.busy       <= (state != IDLE);
            rng.dist_valid <= done_ok || done_to;
            if (done_ok) begin
                rng.dist_cm <= cm_nx;
                rng.timeout <= 1'b0;
            end else if (done_to) begin
                rng.dist_cm <= DIST_MAX;
                rng.timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hcsr04_ranger.sv
// Directed and randomized bench for hcsr04_ranger, scaled to a 2 MHz clock
// with shortened timeout and holdoff so every scenario stays short.
`timescale 1ns/1ps
module tb_hcsr04_ranger;
    localparam int CLK_HZ     = 2000000;
    localparam int CYC        = CLK_HZ / 1000000;
    localparam int TRIG_US    = 10;
    localparam int CM_US      = 58;
    localparam int TIMEOUT_US = 3800;
    localparam int HOLDOFF_US = 600;
    localparam int DIST_W     = 9;
    localparam int DMAX       = (1 << DIST_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hcsr04_ranger_if #(.DIST_W(DIST_W)) rng ();

    hcsr04_ranger #(
        .CLK_HZ    (CLK_HZ),
        .TRIG_US   (TRIG_US),
        .CM_US     (CM_US),
        .TIMEOUT_US(TIMEOUT_US),
        .HOLDOFF_US(HOLDOFF_US),
        .DIST_W    (DIST_W)
    ) dut (
        .clk_clk    (clk),
        .reset_reset(rst),
        .rng        (rng)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Edge-indexed event log, sampled 1 ns after each rising edge.
    int   cyc = 0, valid_cnt = 0, valid_cyc = 0, last_dist = 0, last_to = 0;
    int   rise_cyc = 0, fall_cyc = 0, busy_fall_cyc = 0;
    logic trig_d = 1'b0, busy_d = 1'b0;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (rng.dist_valid === 1'b1) begin
            valid_cnt++;
            valid_cyc = cyc;
            last_dist = int'(rng.dist_cm);
            last_to   = int'(rng.timeout);
        end
        if (rng.trig_out === 1'b1 && trig_d === 1'b0) rise_cyc = cyc;
        if (rng.trig_out === 1'b0 && trig_d === 1'b1) fall_cyc = cyc;
        if (rng.busy === 1'b0 && busy_d === 1'b1) busy_fall_cyc = cyc;
        trig_d = rng.trig_out;
        busy_d = rng.busy;
    end

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: observed no completion, required finish before 95000 cycles");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_win(input string tag, input int obs, input int lo, input int hi);
        vectors++;
        assert (obs >= lo && obs <= hi) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference: whole-µs echo width -> centimetres, or timeout when too long (echo_us < 0: no echo).
    function automatic int model_dist(input int echo_us);
        if (echo_us < 0 || echo_us >= TIMEOUT_US) return DMAX;
        return (echo_us / CM_US > DMAX) ? DMAX : echo_us / CM_US;
    endfunction

    function automatic int model_to(input int echo_us);
        return (echo_us < 0 || echo_us >= TIMEOUT_US) ? 1 : 0;
    endfunction

    task automatic run_meas(input string tag, input int wait_us, input int echo_us, input bit poke);
        int n0, r_drive, f_drive, exp_d, exp_t;
        exp_d = model_dist(echo_us);
        exp_t = model_to(echo_us);
        n0 = valid_cnt;
        rng.start = 1'b1;
        @(negedge clk);
        rng.start = 1'b0;
        check({tag, ".trig_lat"}, rng.trig_out, 1'b0);
        @(negedge clk);
        check({tag, ".trig_on"}, rng.trig_out, 1'b1);
        check({tag, ".busy_on"}, rng.busy, 1'b1);
        for (int i = 0; i < TRIG_US * CYC + 10 && rng.trig_out === 1'b1; i++) @(negedge clk);
        check({tag, ".trig_w"}, fall_cyc - rise_cyc, TRIG_US * CYC);

        if (echo_us >= 0) begin
            cycles(wait_us * CYC);
            rng.echo_in = 1'b1;
            r_drive = cyc;
            for (int i = 0; i < echo_us * CYC; i++) begin
                rng.start = (poke && i == echo_us * CYC / 2);
                @(negedge clk);
            end
            rng.start   = 1'b0;
            rng.echo_in = 1'b0;
            f_drive = cyc;
            for (int i = 0; i < 10 && valid_cnt == n0; i++) @(negedge clk);
            if (exp_t == 0)
                check({tag, ".fall_lat"}, valid_cyc - f_drive, 3);
            else
                check_win({tag, ".to_time"}, valid_cyc - r_drive,
                          TIMEOUT_US * CYC, TIMEOUT_US * CYC + 4);
        end else begin
            for (int i = 0; i < TIMEOUT_US * CYC + 40 && valid_cnt == n0; i++) @(negedge clk);
            check_win({tag, ".to_time"}, valid_cyc - fall_cyc,
                      TIMEOUT_US * CYC - 2, TIMEOUT_US * CYC + 2);
        end
        check({tag, ".nvalid"}, valid_cnt - n0, 1);
        check({tag, ".dist"}, last_dist, exp_d);
        check({tag, ".tout"}, last_to, exp_t);

        if (poke) begin
            cycles(20);
            rng.start = 1'b1;
            @(negedge clk);
            rng.start = 1'b0;
        end
        for (int i = 0; i < HOLDOFF_US * CYC + 20 && rng.busy === 1'b1; i++) @(negedge clk);
        check({tag, ".busy_off"}, rng.busy, 1'b0);
        check_win({tag, ".holdoff"}, busy_fall_cyc - valid_cyc,
                  HOLDOFF_US * CYC - 2, HOLDOFF_US * CYC + 2);
        check({tag, ".held"}, rng.dist_cm, exp_d);
        if (poke) begin
            cycles(10);
            check({tag, ".no_retrig"}, rng.trig_out, 1'b0);
            check({tag, ".one_valid"}, valid_cnt - n0, 1);
        end
    endtask

    initial begin
        int n0, prev_v, w, e;
        rng.start   = 1'b0;
        rng.auto_en = 1'b0;
        rng.echo_in = 1'b0;
        rst         = 1'b1;
        cycles(3);
        check("rst.trig", rng.trig_out, 1'b0);
        check("rst.dist", rng.dist_cm, 0);
        check("rst.valid", rng.dist_valid, 1'b0);
        check("rst.tout", rng.timeout, 1'b0);
        check("rst.busy", rng.busy, 1'b0);
        rst = 1'b0;
        cycles(2);

        run_meas("basic", 100, 580, 1'b0);
        run_meas("w57", 40, 57, 1'b0);
        run_meas("w58", 40, 58, 1'b0);
        run_meas("long", 40, 4000, 1'b0);
        run_meas("noecho", 0, -1, 1'b0);
        run_meas("poke", 30, 300, 1'b1);

        // Reset in the middle of an echo: everything returns to reset values at once.
        n0 = valid_cnt;
        rng.start = 1'b1;
        @(negedge clk);
        rng.start = 1'b0;
        for (int i = 0; i < TRIG_US * CYC + 10 && rng.trig_out !== 1'b0; i++) @(negedge clk);
        cycles(20);
        rng.echo_in = 1'b1;
        cycles(100 * CYC);
        rst = 1'b1;
        @(negedge clk);
        check("mrst.trig", rng.trig_out, 1'b0);
        check("mrst.dist", rng.dist_cm, 0);
        check("mrst.valid", rng.dist_valid, 1'b0);
        check("mrst.tout", rng.timeout, 1'b0);
        check("mrst.busy", rng.busy, 1'b0);
        rng.echo_in = 1'b0;
        cycles(2);
        rst = 1'b0;
        cycles(3);
        check("mrst.nvalid", valid_cnt - n0, 0);
        run_meas("after_rst", 30, 290, 1'b0);

        // Free-running mode: period is trigger + wait + echo + holdoff, plus idle cycle and sync skew.
        n0 = valid_cnt;
        prev_v = 0;
        rng.auto_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < HOLDOFF_US * CYC + 50 && rng.trig_out !== 1'b1; i++) @(negedge clk);
            for (int i = 0; i < TRIG_US * CYC + 10 && rng.trig_out !== 1'b0; i++) @(negedge clk);
            cycles(50 * CYC);
            rng.echo_in = 1'b1;
            cycles(1160 * CYC);
            rng.echo_in = 1'b0;
            for (int i = 0; i < 10 && valid_cnt == n0 + k; i++) @(negedge clk);
            check($sformatf("auto%0d.dist", k), last_dist, 20);
            check($sformatf("auto%0d.tout", k), last_to, 0);
            if (k > 0)
                check_win($sformatf("auto%0d.period", k), valid_cyc - prev_v,
                          (TRIG_US + 50 + 1160 + HOLDOFF_US) * CYC,
                          (TRIG_US + 50 + 1160 + HOLDOFF_US) * CYC + 6);
            prev_v = valid_cyc;
            if (k == 2) rng.auto_en = 1'b0;
        end
        check("auto.nvalid", valid_cnt - n0, 3);
        for (int i = 0; i < HOLDOFF_US * CYC + 20 && rng.busy === 1'b1; i++) @(negedge clk);
        check("auto.stop", rng.busy, 1'b0);

        for (int k = 0; k < 8; k++) begin
            w = int'($urandom_range(200, 5));
            e = int'($urandom_range(1000, 20));
            run_meas($sformatf("rand%0d_e%0d", k, e), w, e, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
